// File: rtl/clk_divider_bank.sv
// Bank of CHANNELS runtime-programmable 50%-duty clock dividers with rise strobes and glitch-free divisor reload.
// Latency: all outputs registered; first rise DEF_HP edges after enable; a new divisor takes effect at the next full-period boundary.
// Backpressure: none, writes are always accepted. Define CLKDIV_BANK_SYNC_EN to add the sync_clr phase-alignment input.
module clk_divider_bank #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 32,
    parameter int DEF_HP   = 500_000,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [CNT_W-1:0]    wr_hp,
`ifdef CLKDIV_BANK_SYNC_EN
    input  logic                sync_clr,
`endif
    output logic [CHANNELS-1:0] clk_div,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] pending
);

    if (CHANNELS < 1 || CHANNELS > 16 || CLK_FREQ < 1) begin : g_bad_cfg
        $error("clk_divider_bank: unsupported CHANNELS or CLK_FREQ");
    end

    logic [CNT_W-1:0]    r_cnt [CHANNELS];
    logic [CNT_W-1:0]    r_hp  [CHANNELS];
    logic [CNT_W-1:0]    r_sh  [CHANNELS];
    logic [CHANNELS-1:0] r_pend;
    logic [CHANNELS-1:0] r_div;
    logic [CHANNELS-1:0] r_rise;

    logic [CNT_W-1:0]    w_wr_val;
    logic [CHANNELS-1:0] w_hit;
    logic [CHANNELS-1:0] w_tc;
    logic [CHANNELS-1:0] w_run;
    logic                w_sync;

`ifdef CLKDIV_BANK_SYNC_EN
    assign w_sync = sync_clr;
`else
    assign w_sync = 1'b0;
`endif

    always_comb begin
        w_wr_val = (wr_hp == '0) ? CNT_W'(1) : wr_hp;
        w_hit    = '0;
        w_tc     = '0;
        w_run    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            // out-of-range wr_ch values match no channel index
            w_hit[c] = wr_en && (wr_ch == CH_W'(c));
            w_tc[c]  = (r_cnt[c] == r_hp[c] - CNT_W'(1));
            w_run[c] = en[c] && !w_sync;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_cnt[c] <= '0;
                r_hp[c]  <= CNT_W'(DEF_HP);
                r_sh[c]  <= CNT_W'(DEF_HP);
            end
            r_pend <= '0;
            r_div  <= '0;
            r_rise <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (!w_run[c] || (w_tc[c] && r_div[c])) begin
                    // idle or full-period boundary: divisor changes land in hp now
                    if (w_hit[c]) begin
                        r_hp[c]   <= w_wr_val;
                        r_sh[c]   <= w_wr_val;
                        r_pend[c] <= 1'b0;
                    end else if (r_pend[c]) begin
                        r_hp[c]   <= r_sh[c];
                        r_pend[c] <= 1'b0;
                    end
                end else if (w_hit[c]) begin
                    r_sh[c]   <= w_wr_val;
                    r_pend[c] <= 1'b1;
                end

                if (!w_run[c]) begin
                    r_cnt[c]  <= '0;
                    r_div[c]  <= 1'b0;
                    r_rise[c] <= 1'b0;
                end else if (w_tc[c]) begin
                    r_cnt[c]  <= '0;
                    r_div[c]  <= ~r_div[c];
                    r_rise[c] <= ~r_div[c];
                end else begin
                    r_cnt[c]  <= r_cnt[c] + CNT_W'(1);
                    r_rise[c] <= 1'b0;
                end
            end
        end
    end

    assign clk_div = r_div;
    assign rise    = r_rise;
    assign pending = r_pend;

endmodule

// File: tb/tb_clk_divider_bank.sv
// Bench for clk_divider_bank: vector table driven through a scoreboard, plus reset and sync_clr sequences.
module tb_clk_divider_bank;

    localparam int CH = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CH-1:0] en = '0;
    logic          wr_en = 1'b0;
    logic [2:0]    wr_ch = '0;
    logic [CW-1:0] wr_hp = '0;
    logic [CH-1:0] clk_div, rise, pending;
`ifdef CLKDIV_BANK_SYNC_EN
    logic          sync_clr = 1'b0;
`endif

    clk_divider_bank #(
        .CLK_FREQ (50_000_000),
        .CHANNELS (CH),
        .CNT_W    (CW),
        .DEF_HP   (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_hp    (wr_hp),
`ifdef CLKDIV_BANK_SYNC_EN
        .sync_clr (sync_clr),
`endif
        .clk_div  (clk_div),
        .rise     (rise),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            hold;
        logic [CH-1:0] en;
        logic          wr_en;
        logic [2:0]    wr_ch;
        logic [CW-1:0] wr_hp;
        logic [CH-1:0] div;
        logic [CH-1:0] rise;
        logic [CH-1:0] pend;
    } vec_t;

    typedef struct {
        logic [CH-1:0] div;
        logic [CH-1:0] rise;
        logic [CH-1:0] pend;
        int            idx;
    } exp_t;

    vec_t tab_a[$];
    vec_t tab_b[$];
    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic vec_t mk(int h, logic [CH-1:0] e, logic w, logic [2:0] ch,
                                logic [CW-1:0] hp, logic [CH-1:0] d, logic [CH-1:0] r,
                                logic [CH-1:0] p);
        vec_t v;
        v.hold = h; v.en = e; v.wr_en = w; v.wr_ch = ch; v.wr_hp = hp;
        v.div = d; v.rise = r; v.pend = p;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Hold a vector's inputs for v.hold edges (write strobe on the first only), then score.
    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            en    = v.en;
            wr_en = (i == 0) ? v.wr_en : 1'b0;
            wr_ch = v.wr_ch;
            wr_hp = v.wr_hp;
            if (i == v.hold - 1) sb.push_back('{v.div, v.rise, v.pend, idx});
            @(posedge clk);
            #1;
        end
        e = sb.pop_front();
        chk($sformatf("v%0d clk_div", e.idx), clk_div, e.div);
        chk($sformatf("v%0d rise", e.idx), rise, e.rise);
        chk($sformatf("v%0d pending", e.idx), pending, e.pend);
    endtask

    localparam logic [CH-1:0] C0 = 5'b00001;
    localparam logic [CH-1:0] C1 = 5'b00010;
    localparam logic [CH-1:0] CB = 5'b00011;
    localparam logic [CH-1:0] Z  = 5'b00000;

    initial begin
        // Channel 0 alone, DEF_HP=5; comments give the edge count since enable.
        tab_a.push_back(mk(4, C0, 0, 0, 0, Z,  Z,  Z));   // E4
        tab_a.push_back(mk(1, C0, 0, 0, 0, C0, C0, Z));   // E5 first rise
        tab_a.push_back(mk(1, C0, 0, 0, 0, C0, Z,  Z));
        tab_a.push_back(mk(3, C0, 0, 0, 0, C0, Z,  Z));   // E9 still high
        tab_a.push_back(mk(1, C0, 0, 0, 0, Z,  Z,  Z));   // E10 fall
        tab_a.push_back(mk(5, C0, 0, 0, 0, C0, C0, Z));   // E15
        tab_a.push_back(mk(1, C0, 1, 0, 3, C0, Z,  C0));  // E16 write 3 mid-high
        tab_a.push_back(mk(3, C0, 0, 0, 0, C0, Z,  C0));  // E19 old period intact
        tab_a.push_back(mk(1, C0, 0, 0, 0, Z,  Z,  Z));   // E20 reload
        tab_a.push_back(mk(3, C0, 0, 0, 0, C0, C0, Z));   // E23
        tab_a.push_back(mk(3, C0, 0, 0, 0, Z,  Z,  Z));   // E26
        tab_a.push_back(mk(3, C0, 0, 0, 0, C0, C0, Z));   // E29
        tab_a.push_back(mk(2, C0, 0, 0, 0, C0, Z,  Z));   // E31
        tab_a.push_back(mk(1, C0, 1, 0, 2, Z,  Z,  Z));   // E32 write on falling toggle
        tab_a.push_back(mk(1, C0, 0, 0, 0, Z,  Z,  Z));
        tab_a.push_back(mk(1, C0, 0, 0, 0, C0, C0, Z));   // E34 hp=2 already
        tab_a.push_back(mk(2, C0, 0, 0, 0, Z,  Z,  Z));   // E36
        tab_a.push_back(mk(1, C0, 1, 0, 0, Z,  Z,  C0));  // E37 write 0
        tab_a.push_back(mk(1, C0, 0, 0, 0, C0, C0, C0));
        tab_a.push_back(mk(2, C0, 0, 0, 0, Z,  Z,  Z));   // E40 reload to 1
        tab_a.push_back(mk(1, C0, 0, 0, 0, C0, C0, Z));
        tab_a.push_back(mk(1, C0, 0, 0, 0, Z,  Z,  Z));
        tab_a.push_back(mk(1, C0, 0, 0, 0, C0, C0, Z));   // E43
        tab_a.push_back(mk(1, C0, 1, 5, 9, Z,  Z,  Z));   // wr_ch=CHANNELS ignored
        tab_a.push_back(mk(1, C0, 0, 0, 0, C0, C0, Z));   // E45 still period 2
        tab_a.push_back(mk(1, C0, 1, 0, 4, Z,  Z,  Z));   // E46 write on fall
        tab_a.push_back(mk(4, C0, 0, 0, 0, C0, C0, Z));   // E50
        tab_a.push_back(mk(2, C0, 0, 0, 0, C0, Z,  Z));   // E52 mid-high
        tab_a.push_back(mk(1, Z,  0, 0, 0, Z,  Z,  Z));   // disable
        tab_a.push_back(mk(1, Z,  1, 0, 7, Z,  Z,  Z));   // write while idle: immediate
        tab_a.push_back(mk(6, C0, 0, 0, 0, Z,  Z,  Z));
        tab_a.push_back(mk(1, C0, 0, 0, 0, C0, C0, Z));   // rise 7 edges after re-enable
        tab_a.push_back(mk(1, C0, 1, 0, 2, C0, Z,  C0));  // pending left for reset

        // After mid-period reset: DEF_HP again, then channel independence.
        tab_b.push_back(mk(4, CB, 0, 0, 0, Z,  Z,  Z));
        tab_b.push_back(mk(1, CB, 0, 0, 0, CB, CB, Z));   // E5 both rise
        tab_b.push_back(mk(1, CB, 1, 1, 2, CB, Z,  C1));  // E6 write ch1
        tab_b.push_back(mk(3, CB, 0, 0, 0, CB, Z,  C1));  // E9
        tab_b.push_back(mk(1, CB, 0, 0, 0, Z,  Z,  Z));   // E10 ch1 reloads
        tab_b.push_back(mk(2, CB, 0, 0, 0, C1, C1, Z));   // E12
        tab_b.push_back(mk(2, CB, 0, 0, 0, Z,  Z,  Z));   // E14
        tab_b.push_back(mk(1, CB, 0, 0, 0, C0, C0, Z));   // E15 ch0 undisturbed

        #2;
        chk("reset clk_div", clk_div, Z);
        chk("reset rise", rise, Z);
        chk("reset pending", pending, Z);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tab_a.size(); i++) run_vec(tab_a[i], i);

        @(negedge clk);
        wr_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async rst clk_div", clk_div, Z);
        chk("async rst rise", rise, Z);
        chk("async rst pending", pending, Z);
        en = Z;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tab_b.size(); i++) run_vec(tab_b[i], 100 + i);

`ifdef CLKDIV_BANK_SYNC_EN
        @(negedge clk);
        en = Z;
        wr_en = 1'b1; wr_ch = 3'd0; wr_hp = 16'd4;
        @(negedge clk);
        wr_ch = 3'd1; wr_hp = 16'd6;
        @(negedge clk);
        wr_en = 1'b0;
        en = CB;
        repeat (11) @(negedge clk);
        sync_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("sync clk_div low", clk_div & CB, Z);
        @(negedge clk);
        sync_clr = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            logic [CH-1:0] er;
            er = '0;
            er[0] = (k == 4);
            er[1] = (k == 6);
            @(posedge clk);
            #1;
            chk($sformatf("sync rise k%0d", k), rise & CB, er);
        end
`endif

        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard leftover: got %0d expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
